// File: rtl/sdram_responder.sv
`timescale 1ns/1ps
// Behavioural SDRAM device for controller verification: command decode, bank/tRCD
// tracking, mode register, refresh counting, pipelined CAS-latency reads, sticky errors.
module sdram_responder #(
  parameter int ROW_BITS = 4,
  parameter int COL_BITS = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sd_cs_n,
  input  logic        sd_ras_n,
  input  logic        sd_cas_n,
  input  logic        sd_we_n,
  input  logic [1:0]  sd_ba,
  input  logic [12:0] sd_a,
  input  logic        sd_dqml,
  input  logic        sd_dqmh,
  input  logic [15:0] sd_dq_in,
  output logic [15:0] sd_dq_out,
  output logic        sd_dq_oe,
  output logic        initialized,
  output logic [2:0]  mode_cl,
  output logic [15:0] refresh_cnt,
  output logic        err,
  output logic [2:0]  err_code
);

  localparam int ADDR_BITS = 2 + ROW_BITS + COL_BITS;
  localparam int DEPTH     = 1 << ADDR_BITS;

  typedef enum logic [2:0] {
    CMD_NOP, CMD_ACTIVE, CMD_READ, CMD_WRITE, CMD_PRECHARGE, CMD_REFRESH, CMD_LOAD_MODE
  } cmd_e;

  cmd_e                 cmd_s;
  logic [3:0]           open_r;
  logic [ROW_BITS-1:0]  row_r [4];
  logic [1:0]           trcd_r [4];
  logic [15:0]          mem [DEPTH];
  logic                 acc_rd_s, acc_wr_s, err_hit_s, lm_ok_s, fwd_s;
  logic [2:0]           err_new_s;
  logic [ADDR_BITS-1:0] addr_s;
  logic                 p1_valid_r, p2_valid_r;
  logic [ADDR_BITS-1:0] p1_addr_r, p2_addr_r;
  logic [1:0]           p1_mask_r, p2_mask_r;
  logic [15:0]          stored_s, rd_word_s, rd_data_s;
  logic                 unused_a_s;

  assign unused_a_s = ^sd_a;

  // Decode the command pins; INHIBIT and BURST_TERMINATE behave as NOP
  always_comb begin
    cmd_s = CMD_NOP;
    if (sd_cs_n) begin
      cmd_s = CMD_NOP;
    end else begin
      case ({sd_ras_n, sd_cas_n, sd_we_n})
        3'b011:  cmd_s = CMD_ACTIVE;
        3'b101:  cmd_s = CMD_READ;
        3'b100:  cmd_s = CMD_WRITE;
        3'b010:  cmd_s = CMD_PRECHARGE;
        3'b001:  cmd_s = CMD_REFRESH;
        3'b000:  cmd_s = CMD_LOAD_MODE;
        default: cmd_s = CMD_NOP;
      endcase
    end
  end

  assign addr_s  = {sd_ba, row_r[sd_ba], sd_a[COL_BITS-1:0]};
  assign lm_ok_s = (open_r == 4'b0000) && ((sd_a[6:4] == 3'd2) || (sd_a[6:4] == 3'd3))
                   && (sd_a[2:0] == 3'd0);

  // Command legality and error classification
  always_comb begin
    acc_rd_s  = 1'b0;
    acc_wr_s  = 1'b0;
    err_hit_s = 1'b0;
    err_new_s = 3'd0;
    case (cmd_s)
      CMD_LOAD_MODE: begin
        if (!lm_ok_s) begin
          err_hit_s = 1'b1;
          err_new_s = 3'd6;
        end else begin
          err_hit_s = 1'b0;
        end
      end
      CMD_ACTIVE: begin
        if (open_r[sd_ba]) begin
          err_hit_s = 1'b1;
          err_new_s = 3'd3;
        end else begin
          err_hit_s = 1'b0;
        end
      end
      CMD_REFRESH: begin
        if (open_r != 4'b0000) begin
          err_hit_s = 1'b1;
          err_new_s = 3'd5;
        end else begin
          err_hit_s = 1'b0;
        end
      end
      CMD_READ, CMD_WRITE: begin
        if (!initialized) begin
          err_hit_s = 1'b1;
          err_new_s = 3'd1;
        end else if (!open_r[sd_ba]) begin
          err_hit_s = 1'b1;
          err_new_s = 3'd2;
        // the counter reaches zero on this very edge when it holds 1
        end else if (trcd_r[sd_ba] > 2'd1) begin
          err_hit_s = 1'b1;
          err_new_s = 3'd4;
        end else if (cmd_s == CMD_READ) begin
          acc_rd_s = 1'b1;
        end else begin
          acc_wr_s = 1'b1;
          if (sd_dq_oe) begin
            err_hit_s = 1'b1;
            err_new_s = 3'd7;
          end else begin
            err_hit_s = 1'b0;
          end
        end
      end
      default: err_hit_s = 1'b0;
    endcase
  end

  // Per-bank open/row/tRCD state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      open_r <= 4'b0000;
      for (int b = 0; b < 4; b++) begin
        row_r[b]  <= '0;
        trcd_r[b] <= 2'd0;
      end
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (trcd_r[b] != 2'd0) trcd_r[b] <= trcd_r[b] - 2'd1;
      end
      if (cmd_s == CMD_ACTIVE && !open_r[sd_ba]) begin
        open_r[sd_ba] <= 1'b1;
        row_r[sd_ba]  <= sd_a[ROW_BITS-1:0];
        trcd_r[sd_ba] <= 2'd2;
      end
      if (cmd_s == CMD_PRECHARGE) begin
        if (sd_a[10]) open_r <= 4'b0000;
        else          open_r[sd_ba] <= 1'b0;
      end
    end
  end

  // Mode register, refresh counter and first-error capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      initialized <= 1'b0;
      mode_cl     <= 3'd0;
      refresh_cnt <= 16'h0000;
      err         <= 1'b0;
      err_code    <= 3'd0;
    end else begin
      if (cmd_s == CMD_LOAD_MODE && lm_ok_s) begin
        mode_cl     <= sd_a[6:4];
        initialized <= 1'b1;
      end
      if (cmd_s == CMD_REFRESH && open_r == 4'b0000) refresh_cnt <= refresh_cnt + 16'd1;
      if (err_hit_s && !err) begin
        err      <= 1'b1;
        err_code <= err_new_s;
      end
    end
  end

  // Storage array, intentionally untouched by reset
  always_ff @(posedge clk) begin
    if (acc_wr_s) begin
      if (!sd_dqml) mem[addr_s][7:0]  <= sd_dq_in[7:0];
      if (!sd_dqmh) mem[addr_s][15:8] <= sd_dq_in[15:8];
    end
  end

  // Array is read on the drive edge, so a write on that same edge is forwarded
  assign stored_s  = mem[p1_addr_r];
  assign fwd_s     = acc_wr_s && (addr_s == p1_addr_r);
  assign rd_word_s = {(fwd_s && !sd_dqmh) ? sd_dq_in[15:8] : stored_s[15:8],
                      (fwd_s && !sd_dqml) ? sd_dq_in[7:0]  : stored_s[7:0]};
  assign rd_data_s = {p1_mask_r[1] ? 8'h00 : rd_word_s[15:8],
                      p1_mask_r[0] ? 8'h00 : rd_word_s[7:0]};

  // Read latency pipeline: CL3 reads enter stage 2, CL2 reads enter stage 1
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p2_valid_r <= 1'b0;
      p2_addr_r  <= '0;
      p2_mask_r  <= 2'b00;
      p1_valid_r <= 1'b0;
      p1_addr_r  <= '0;
      p1_mask_r  <= 2'b00;
      sd_dq_oe   <= 1'b0;
      sd_dq_out  <= 16'h0000;
    end else begin
      p2_valid_r <= acc_rd_s && (mode_cl == 3'd3);
      p2_addr_r  <= addr_s;
      p2_mask_r  <= {sd_dqmh, sd_dqml};
      if (acc_rd_s && (mode_cl != 3'd3)) begin
        p1_valid_r <= 1'b1;
        p1_addr_r  <= addr_s;
        p1_mask_r  <= {sd_dqmh, sd_dqml};
      end else begin
        p1_valid_r <= p2_valid_r;
        p1_addr_r  <= p2_addr_r;
        p1_mask_r  <= p2_mask_r;
      end
      sd_dq_oe  <= p1_valid_r;
      sd_dq_out <= p1_valid_r ? rd_data_s : 16'h0000;
    end
  end

endmodule

// File: tb/tb_sdram_responder.sv
`timescale 1ns/1ps
// Scoreboard bench for sdram_responder: directed scenarios plus random command traffic
// checked against a command-level reference model of the SDRAM rules.
module tb_sdram_responder;
  localparam int ROW_BITS = 4;
  localparam int COL_BITS = 8;
  localparam bit [3:0] C_NOP = 4'b0111, C_ACT = 4'b0011, C_RD = 4'b0101, C_WR = 4'b0100;
  localparam bit [3:0] C_BT = 4'b0110, C_PRE = 4'b0010, C_REF = 4'b0001, C_LMR = 4'b0000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n, sd_dqml, sd_dqmh;
  logic [1:0] sd_ba;
  logic [12:0] sd_a;
  logic [15:0] sd_dq_in, sd_dq_out, refresh_cnt;
  logic sd_dq_oe, initialized, err;
  logic [2:0] mode_cl, err_code;

  sdram_responder #(.ROW_BITS(ROW_BITS), .COL_BITS(COL_BITS)) dut (
    .clk(clk), .reset_n(reset_n), .sd_cs_n(sd_cs_n), .sd_ras_n(sd_ras_n),
    .sd_cas_n(sd_cas_n), .sd_we_n(sd_we_n), .sd_ba(sd_ba), .sd_a(sd_a),
    .sd_dqml(sd_dqml), .sd_dqmh(sd_dqmh), .sd_dq_in(sd_dq_in), .sd_dq_out(sd_dq_out),
    .sd_dq_oe(sd_dq_oe), .initialized(initialized), .mode_cl(mode_cl),
    .refresh_cnt(refresh_cnt), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int errors = 0;
  int checks = 0;
  int beats_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // reference model state
  typedef struct {int de; int addr; bit ml; bit mh;} beat_t;
  beat_t q[$];
  bit m_open[4];
  int m_row[4];
  int m_act[4];
  bit m_init;
  int m_cl;
  logic [15:0] m_ref;
  bit m_err;
  int m_code;
  logic [15:0] m_mem [int];
  bit m_busy [int];

  function automatic void m_raise(input int c);
    if (!m_err) begin
      m_err = 1'b1;
      m_code = c;
    end
  endfunction

  function automatic void m_reset();
    for (int b = 0; b < 4; b++) m_open[b] = 1'b0;
    m_init = 1'b0; m_cl = 0; m_ref = 16'h0; m_err = 1'b0; m_code = 0;
    q.delete();
    m_busy.delete();
  endfunction

  function automatic bit any_open();
    return m_open[0] | m_open[1] | m_open[2] | m_open[3];
  endfunction

  function automatic int addr_of(input int ba, input int row, input int col);
    return ba * (1 << (ROW_BITS + COL_BITS)) + row * (1 << COL_BITS) + col;
  endfunction

  function automatic void m_step(input bit [3:0] cmd, input int ba, input logic [12:0] a,
                                 input bit ml, input bit mh, input logic [15:0] din, input int e);
    int ad;
    logic [15:0] old;
    if (cmd[3]) return;
    case (cmd)
      C_LMR: begin
        if (!any_open() && (a[6:4] == 3'd2 || a[6:4] == 3'd3) && a[2:0] == 3'd0) begin
          m_cl = int'(a[6:4]);
          m_init = 1'b1;
        end else m_raise(6);
      end
      C_ACT: begin
        if (m_open[ba]) m_raise(3);
        else begin
          m_open[ba] = 1'b1;
          m_row[ba] = int'(a[ROW_BITS-1:0]);
          m_act[ba] = e;
        end
      end
      C_PRE: begin
        if (a[10]) for (int b = 0; b < 4; b++) m_open[b] = 1'b0;
        else m_open[ba] = 1'b0;
      end
      C_REF: begin
        if (any_open()) m_raise(5);
        else m_ref = m_ref + 16'd1;
      end
      C_RD, C_WR: begin
        if (!m_init) m_raise(1);
        else if (!m_open[ba]) m_raise(2);
        else if (e - m_act[ba] < 2) m_raise(4);
        else begin
          ad = addr_of(ba, m_row[ba], int'(a[COL_BITS-1:0]));
          if (cmd == C_RD) begin
            m_busy[e + m_cl - 1] = 1'b1;
            q.push_back('{e + m_cl - 1, ad, ml, mh});
          end else begin
            if (m_busy.exists(e - 1)) m_raise(7);
            old = m_mem.exists(ad) ? m_mem[ad] : 16'h0000;
            m_mem[ad] = {mh ? old[15:8] : din[15:8], ml ? old[7:0] : din[7:0]};
          end
        end
      end
      default: ;
    endcase
  endfunction

  // monitor: pops the scoreboard whenever the DUT drives data
  initial begin
    beat_t b;
    logic [15:0] w;
    forever begin
      @(posedge clk);
      #2;
      if (sd_dq_oe) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_oe: sd_dq_oe=1 data %0h at edge %0d, no read pending", sd_dq_out, cyc);
        end else begin
          b = q.pop_front();
          w = m_mem.exists(b.addr) ? m_mem[b.addr] : 16'h0000;
          check("beat_edge", cyc, b.de);
          check("beat_data", sd_dq_out, {b.mh ? 8'h00 : w[15:8], b.ml ? 8'h00 : w[7:0]});
          beats_seen++;
        end
      end else begin
        check("idle_dq", sd_dq_out, 16'h0000);
        if (q.size() > 0 && q[0].de <= cyc) begin
          b = q.pop_front();
          checks++; errors++;
          $display("FAIL missed_beat: sd_dq_oe=0 at edge %0d, required 1 for edge %0d", cyc, b.de);
        end
      end
    end
  end

  task automatic issue(input bit [3:0] cmd, input int ba, input logic [12:0] a,
                       input bit ml = 1'b0, input bit mh = 1'b0, input logic [15:0] din = 16'h0);
    @(negedge clk);
    {sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n} = cmd;
    sd_ba = 2'(ba); sd_a = a; sd_dqml = ml; sd_dqmh = mh; sd_dq_in = din;
    m_step(cmd, ba, a, ml, mh, din, cyc + 1);
    @(posedge clk);
    #1;
    {sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n} = C_NOP;
    sd_dqml = 1'b0; sd_dqmh = 1'b0; sd_dq_in = 16'h0;
  endtask

  task automatic nops(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    m_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag);
    check({tag, "_init"}, initialized, m_init);
    check({tag, "_cl"}, mode_cl, m_cl);
    check({tag, "_refcnt"}, refresh_cnt, m_ref);
    check({tag, "_err"}, err, m_err);
    check({tag, "_code"}, err_code, m_code);
  endtask

  initial begin
    int beats0, r, ba;
    logic [12:0] a;
    logic [12:0] lm_tab [4];
    lm_tab = '{13'h220, 13'h230, 13'h210, 13'h221};
    {sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n} = C_NOP;
    sd_ba = 2'd0; sd_a = 13'h0; sd_dqml = 1'b0; sd_dqmh = 1'b0; sd_dq_in = 16'h0;
    m_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check_status("reset");

    // access before initialisation, then ACTIVE on an open bank keeps the first code
    issue(C_RD, 0, 13'h0);
    nops(4);
    issue(C_ACT, 0, 13'h5);
    issue(C_ACT, 0, 13'h5);
    check_status("rd_uninit");

    do_reset();
    issue(C_ACT, 2, 13'h1);
    issue(C_REF, 0, 13'h0);
    check_status("ref_open");

    do_reset();
    issue(C_PRE, 0, 13'h400);
    repeat (8) issue(C_REF, 0, 13'h0);
    issue(C_LMR, 0, 13'h220);
    check_status("init");

    issue(C_ACT, 1, 13'h3);
    nops(1);
    issue(C_WR, 1, 13'h10, 1'b0, 1'b0, 16'hA55A);
    issue(C_RD, 1, 13'h10);
    nops(4);
    check_status("rw");

    issue(C_WR, 1, 13'h10, 1'b0, 1'b1, 16'h1234);
    issue(C_PRE, 0, 13'h400);
    issue(C_LMR, 0, 13'h230);
    issue(C_ACT, 1, 13'h3);
    nops(1);
    issue(C_RD, 1, 13'h10);
    issue(C_RD, 1, 13'h10, 1'b1, 1'b0);
    issue(C_BT, 0, 13'h0);
    nops(5);
    check_status("cl3");

    // write landing on the read's drive edge is returned by that read
    issue(C_WR, 1, 13'h20, 1'b0, 1'b0, 16'h1111);
    nops(3);
    issue(C_RD, 1, 13'h20);
    nops(1);
    issue(C_WR, 1, 13'h20, 1'b0, 1'b0, 16'h2222);
    nops(4);

    // write while read data is on the bus
    issue(C_RD, 1, 13'h10);
    nops(2);
    issue(C_WR, 1, 13'h30, 1'b0, 1'b0, 16'hBEEF);
    check_status("contention");
    nops(2);
    issue(C_RD, 1, 13'h30);
    nops(5);

    beats0 = beats_seen;
    repeat (4) issue(C_RD, 1, 13'h10);
    do_reset();
    nops(10);
    check("rst_beats", beats_seen - beats0, 2);
    check_status("post_rst");

    issue(C_PRE, 0, 13'h400);
    issue(C_LMR, 0, 13'h220);
    issue(C_ACT, 0, 13'h5);
    nops(1);
    issue(C_WR, 0, 13'h4, 1'b0, 1'b0, 16'h1111);
    issue(C_PRE, 0, 13'h000);
    issue(C_ACT, 0, 13'h5);
    issue(C_WR, 0, 13'h4, 1'b0, 1'b0, 16'h2222);
    nops(1);
    issue(C_RD, 0, 13'h4);
    nops(4);
    check_status("trcd");

    // random traffic
    do_reset();
    issue(C_PRE, 0, 13'h400);
    issue(C_LMR, 0, ($urandom_range(0, 1) != 0) ? 13'h230 : 13'h220);
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      ba = $urandom_range(0, 3);
      a = 13'($urandom);
      a[7:0] = 8'($urandom_range(0, 7));
      if (r < 12) issue(C_ACT, ba, 13'($urandom));
      else if (r < 20) issue(C_PRE, ba, 13'($urandom));
      else if (r < 50) begin
        if (m_mem.exists(addr_of(ba, m_row[ba], int'(a[7:0]))))
          issue(C_WR, ba, a, 1'($urandom), 1'($urandom), 16'($urandom));
        else
          issue(C_WR, ba, a, 1'b0, 1'b0, 16'($urandom));
      end else if (r < 85) begin
        if (m_open[ba] && !m_mem.exists(addr_of(ba, m_row[ba], int'(a[7:0]))))
          issue(C_WR, ba, a, 1'b0, 1'b0, 16'($urandom));
        else
          issue(C_RD, ba, a, 1'($urandom), 1'($urandom));
      end else if (r < 90) issue(C_REF, ba, a);
      else if (r < 93) issue(C_LMR, 0, lm_tab[$urandom_range(0, 3)]);
      else if (r < 96) issue(C_BT, ba, a);
      else issue({1'b1, 3'($urandom)}, ba, a);
      check_status("rand");
    end
    nops(8);
    check("drain", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
